// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller: per-port request tracking, response hold, stage enables.
// Optional per-port wait watchdog enabled by defining HAZARD_TIMEOUT_EN.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int NUM_PORTS   = 2,
  parameter int DATA_W      = 32,
  parameter int STALL_STAGE = 2,
  parameter int FLUSH_DEPTH = 2,
  parameter int MAX_WAIT    = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS-1:0]        resp,
  input  logic [NUM_PORTS*DATA_W-1:0] rdata,
  input  logic                        load_use,
  input  logic                        flush,
  output logic [NUM_PORTS-1:0]        req_ok,
  output logic [NUM_PORTS*DATA_W-1:0] held_rdata,
  output logic                        move,
  output logic [NUM_STAGES-1:0]       advance,
  output logic [NUM_STAGES-1:0]       bubble,
  output logic                        error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } st_t;

  st_t               st_q   [NUM_PORTS];
  logic [DATA_W-1:0] hold_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] idle;
  logic [NUM_PORTS-1:0] fin;
  logic [NUM_PORTS-1:0] tmo;

  // Global step: every port idle or finishing; never during reset.
  assign move   = rst && (&(idle | fin));
  assign req_ok = idle | {NUM_PORTS{move}};

`ifdef HAZARD_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q [NUM_PORTS];
  logic          err_q;

  // Sticky error on any port watchdog expiry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else if (|tmo) err_q <= 1'b1;
  end

  assign error = err_q;
`else
  wire unused_cfg = ^MAX_WAIT;
  assign tmo   = '0;
  assign error = 1'b0;
`endif

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [DATA_W-1:0] rd;
    assign rd   = rdata[p*DATA_W +: DATA_W];
    assign idle[p] = (st_q[p] == IDLE);
    assign fin[p]  = (st_q[p] == DONE) ||
                     ((st_q[p] == WAIT) && resp[p]);
    assign held_rdata[p*DATA_W +: DATA_W] =
      resp[p] ? rd : hold_q[p];

`ifdef HAZARD_TIMEOUT_EN
    assign tmo[p] = (st_q[p] == WAIT) && !resp[p] &&
                    (cnt_q[p] == CW'(MAX_WAIT - 1));

    // Cycles spent waiting; restarts on every fresh WAIT entry.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q[p] <= '0;
      else if ((st_q[p] == WAIT) && !fin[p])
        cnt_q[p] <= cnt_q[p] + 1'b1;
      else cnt_q[p] <= '0;
    end
`endif

    // Port request tracker and response hold register.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_q[p]   <= IDLE;
        hold_q[p] <= '0;
      end else begin
        unique case (st_q[p])
          IDLE: begin
            if (req[p] && resp[p]) begin
              st_q[p]   <= DONE;
              hold_q[p] <= rd;
            end else if (req[p]) begin
              st_q[p] <= WAIT;
            end
          end
          WAIT: begin
            if (resp[p]) begin
              hold_q[p] <= rd;
              if (!move) st_q[p] <= DONE;
              else if (req[p]) st_q[p] <= WAIT;
              else st_q[p] <= IDLE;
            end else if (tmo[p]) begin
              st_q[p]   <= DONE;
              hold_q[p] <= '0;
            end
          end
          DONE: begin
            if (move) st_q[p] <= req[p] ? WAIT : IDLE;
          end
          default: st_q[p] <= IDLE;
        endcase
      end
    end
  end

  // Stage enables: flush beats load-use, both gated by move.
  always_comb begin
    advance = '0;
    bubble  = '0;
    unique case (1'b1)
      move && flush: begin
        advance = '1;
        for (int k = 0; k < NUM_STAGES; k++)
          bubble[k] = (k >= 1) && (k <= FLUSH_DEPTH);
      end
      move && !flush && load_use: begin
        for (int k = 0; k < NUM_STAGES; k++)
          advance[k] = (k >= STALL_STAGE);
        bubble[STALL_STAGE] = 1'b1;
      end
      default: advance = {NUM_STAGES{move}};
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl.
// Watchdog section follows HAZARD_TIMEOUT_EN.
module tb_pipe_hazard_ctrl;

`ifdef HAZARD_TIMEOUT_EN
  localparam int MW = 8;
`else
  localparam int MW = 255;
`endif

  localparam logic [31:0] G = 32'hAAAA_AAAA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req = '0;
  logic [1:0]  resp = '0;
  logic [63:0] rdata = '0;
  logic        load_use = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  req_ok;
  logic [63:0] held_rdata;
  logic        move;
  logic [4:0]  advance;
  logic [4:0]  bubble;
  logic        error;

  pipe_hazard_ctrl #(
    .NUM_STAGES(5), .NUM_PORTS(2), .DATA_W(32),
    .STALL_STAGE(2), .FLUSH_DEPTH(2), .MAX_WAIT(MW)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .resp(resp),
    .rdata(rdata), .load_use(load_use), .flush(flush),
    .req_ok(req_ok), .held_rdata(held_rdata),
    .move(move), .advance(advance), .bubble(bubble),
    .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       nm;
    logic        mv;
    logic [4:0]  adv;
    logic [4:0]  bub;
    logic [1:0]  rok;
    logic        er;
    logic [1:0]  hm;
    logic [31:0] h0;
    logic [31:0] h1;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  logic ee = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the expectation stamped for this cycle.
  always @(negedge clk) begin
    for (int p = 0; p < 2; p++)
      if (req[p])
        chk($sformatf("proto%0d", p), 64'(req_ok[p]), 64'd1);
    if (q.size() > 0 && q[0].cyc < cyc) begin
      me = q.pop_front();
      chk({me.nm, ".missed"}, 64'(cyc), 64'(me.cyc));
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      me = q.pop_front();
      chk({me.nm, ".move"}, 64'(move), 64'(me.mv));
      chk({me.nm, ".adv"}, 64'(advance), 64'(me.adv));
      chk({me.nm, ".bub"}, 64'(bubble), 64'(me.bub));
      chk({me.nm, ".rok"}, 64'(req_ok), 64'(me.rok));
      chk({me.nm, ".err"}, 64'(error), 64'(me.er));
      if (me.hm[0])
        chk({me.nm, ".h0"}, 64'(held_rdata[31:0]), 64'(me.h0));
      if (me.hm[1])
        chk({me.nm, ".h1"}, 64'(held_rdata[63:32]), 64'(me.h1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic [1:0] rq, input logic [1:0] rs,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic lu, input logic fl);
    req = rq;
    resp = rs;
    rdata = {d1, d0};
    load_use = lu;
    flush = fl;
  endtask

  task automatic ex(input string nm, input logic mv,
                    input logic [4:0] adv, input logic [4:0] bub,
                    input logic [1:0] rok, input logic er,
                    input logic [1:0] hm,
                    input logic [31:0] h0, input logic [31:0] h1);
    exp_t e;
    e.cyc = cyc; e.nm = nm; e.mv = mv; e.adv = adv;
    e.bub = bub; e.rok = rok; e.er = er; e.hm = hm;
    e.h0 = h0; e.h1 = h1;
    q.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "timeout");
  end

  initial begin
    drv(0, 0, 0, 0, 0, 0);
    step(); step();
    ex("rst", 0, 0, 0, 3, 0, 3, 0, 0);

    step(); rst = 1'b1; drv(0, 0, G, G, 0, 0);
    ex("t1", 1, 5'h1F, 0, 3, 0, 0, 0, 0);

    step(); drv(2'b01, 0, G, G, 0, 0);
    ex("t2.iss", 1, 5'h1F, 0, 3, 0, 0, 0, 0);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t2.w1", 0, 0, 0, 2'b10, 0, 0, 0, 0);
    step();
    ex("t2.w2", 0, 0, 0, 2'b10, 0, 0, 0, 0);
    step(); drv(0, 2'b01, 32'h13, G, 0, 0);
    ex("t2.rsp", 1, 5'h1F, 0, 3, 0, 2'b01, 32'h13, 0);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t2.hold", 1, 5'h1F, 0, 3, 0, 2'b01, 32'h13, 0);

    step(); drv(2'b11, 0, G, G, 0, 0);
    ex("t3.iss", 1, 5'h1F, 0, 3, 0, 0, 0, 0);
    step(); drv(0, 2'b01, 32'h1111, G, 0, 0);
    ex("t3.c1", 0, 0, 0, 0, 0, 2'b01, 32'h1111, 0);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t3.c2", 0, 0, 0, 0, 0, 2'b01, 32'h1111, 0);
    step();
    ex("t3.c3", 0, 0, 0, 0, 0, 2'b01, 32'h1111, 0);
    step(); drv(0, 2'b10, G, 32'hDEAD_BEEF, 0, 0);
    ex("t3.c4", 1, 5'h1F, 0, 3, 0, 3, 32'h1111, 32'hDEAD_BEEF);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t3.c5", 1, 5'h1F, 0, 3, 0, 3, 32'h1111, 32'hDEAD_BEEF);

    step(); drv(2'b01, 0, G, G, 0, 0);
    ex("t4.iss", 1, 5'h1F, 0, 3, 0, 0, 0, 0);
    step(); drv(0, 0, G, G, 1, 0);
    ex("t4.stall", 0, 0, 0, 2'b10, 0, 0, 0, 0);
    step(); drv(0, 2'b01, 32'h77, G, 1, 0);
    ex("t4.mv", 1, 5'b11100, 5'b00100, 3, 0, 2'b01, 32'h77, 0);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t4.after", 1, 5'h1F, 0, 3, 0, 2'b01, 32'h77, 0);

    step(); drv(2'b10, 0, G, G, 0, 0);
    ex("t5.iss", 1, 5'h1F, 0, 3, 0, 0, 0, 0);
    step(); drv(0, 0, G, G, 1, 1);
    ex("t5.stall", 0, 0, 0, 2'b01, 0, 0, 0, 0);
    step(); drv(0, 2'b10, G, 32'h55, 1, 1);
    ex("t5.mv", 1, 5'h1F, 5'b00110, 3, 0, 2'b10, 0, 32'h55);
    step(); drv(0, 0, G, G, 0, 1);
    ex("t5.fl", 1, 5'h1F, 5'b00110, 3, 0, 2'b10, 0, 32'h55);
    step(); drv(0, 0, G, G, 1, 0);
    ex("t5.lu", 1, 5'b11100, 5'b00100, 3, 0, 0, 0, 0);

    step(); drv(2'b01, 2'b01, 32'h21, G, 0, 0);
    ex("sc0", 1, 5'h1F, 0, 3, 0, 2'b01, 32'h21, 0);
    step(); drv(2'b01, 2'b01, 32'h22, G, 0, 0);
    ex("sc1", 1, 5'h1F, 0, 3, 0, 2'b01, 32'h22, 0);
    step(); drv(2'b01, 2'b01, 32'h23, G, 0, 0);
    ex("sc2", 1, 5'h1F, 0, 3, 0, 2'b01, 32'h23, 0);
    step(); drv(0, 2'b01, 32'h24, G, 0, 0);
    ex("sc3", 1, 5'h1F, 0, 3, 0, 2'b01, 32'h24, 0);
    step(); drv(0, 0, G, G, 0, 0);
    ex("sc4", 1, 5'h1F, 0, 3, 0, 2'b01, 32'h24, 0);

    step(); drv(2'b10, 0, G, G, 0, 0);
    ex("t6.iss", 1, 5'h1F, 0, 3, 0, 0, 0, 0);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t6.w1", 0, 0, 0, 2'b01, 0, 2'b10, 0, 32'h55);
    repeat (6) step();
    step();
    ex("t6.w8", 0, 0, 0, 2'b01, 0, 2'b10, 0, 32'h55);
`ifdef HAZARD_TIMEOUT_EN
    step();
    ex("t6.tmo", 1, 5'h1F, 0, 3, 1, 2'b10, 0, 0);
    ee = 1'b1;
    step();
    ex("t6.sticky", 1, 5'h1F, 0, 3, 1, 2'b10, 0, 0);
`else
    repeat (12) step();
    ex("t6.w20", 0, 0, 0, 2'b01, 0, 2'b10, 0, 32'h55);
    step(); drv(0, 2'b10, G, 32'h66, 0, 0);
    ex("t6.rsp", 1, 5'h1F, 0, 3, 0, 2'b10, 0, 32'h66);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t6.done", 1, 5'h1F, 0, 3, 0, 2'b10, 0, 32'h66);
`endif

    step(); drv(2'b10, 0, G, G, 0, 0);
    ex("t8.iss", 1, 5'h1F, 0, 3, ee, 0, 0, 0);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t8.w", 0, 0, 0, 2'b01, ee, 0, 0, 0);
    step(); rst = 1'b0;
    ex("t8.rst", 0, 0, 0, 3, 0, 3, 0, 0);
    ee = 1'b0;
    step(); rst = 1'b1; drv(0, 2'b10, G, 32'h99, 0, 0);
    ex("t8.late", 1, 5'h1F, 0, 3, 0, 0, 0, 0);
    step(); drv(0, 0, G, G, 0, 0);
    ex("t8.ign", 1, 5'h1F, 0, 3, 0, 3, 0, 0);

    step(); step();
    chk("drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised stall/flush controller for the in-order pipeline, replacing the fixed two-port back-pressure stall unit. It tracks outstanding requests on NUM_PORTS multi-cycle memory ports and buffers early responses. It generates per-stage advance and bubble enables for NUM_STAGES stage registers, adding load-use stall and redirect-flush support.

Parameters:
NUM_STAGES, 5, number of stage registers driven; index 0 = fetch side.
NUM_PORTS, 2, number of memory ports tracked; port 0 = instruction port.
DATA_W, 32, response data width per port.
STALL_STAGE, 2, first stage index that keeps advancing on a load-use stall; it receives the bubble.
FLUSH_DEPTH, 2, stages 1..FLUSH_DEPTH are bubbled on flush.
MAX_WAIT, 255, watchdog limit in cycles; used only with the optional feature.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
req  in  NUM_PORTS  port p issues a request this cycle; honoured only when req_ok[p]=1
resp  in  NUM_PORTS  port p response valid this cycle
rdata  in  NUM_PORTS*DATA_W  response data, port p at bits [p*DATA_W +: DATA_W]
load_use  in  1  decode detects a load-use hazard
flush  in  1  redirect (taken branch/jump) resolved this cycle
req_ok  out  NUM_PORTS  port p may issue a new request
held_rdata  out  NUM_PORTS*DATA_W  response data for port p, stable while move=0
move  out  1  global step; all ports complete this cycle
advance  out  NUM_STAGES  stage-register load enable
bubble  out  NUM_STAGES  stage k loads an invalid/NOP entry when advance[k]=1
error  out  1  sticky watchdog error; constant 0 without the optional feature

Behaviour:
- Per-port FSM with states IDLE, WAIT and DONE.
  - IDLE: req=1 and resp=0 -> WAIT. req=1 and resp=1 (same cycle) -> DONE and capture rdata.
  - WAIT: resp=1 -> DONE and capture rdata into the hold register. Otherwise stay in WAIT.
  - DONE: hold the captured data and ignore resp. On move, go to IDLE, or to WAIT if req=1 that cycle.
- resp arriving in IDLE with no req is ignored.
- held_rdata[p] = rdata[p] when resp[p]=1 in that cycle; otherwise the hold register.
- move (combinational) = 1 when every port is IDLE, or is completing this cycle (DONE, or WAIT with resp=1).
- move is forced to 0 while rst=0.
- req_ok[p] = (state==IDLE) or move.
  - A req with req_ok=0 is a protocol violation. The bench flags it; the RTL ignores it.
- Default stepping: advance[k] = move for all k, and bubble = 0.
- load_use=1 with move=1:
  - advance[k]=0 for k < STALL_STAGE.
  - advance[k]=1 for k >= STALL_STAGE.
  - bubble[STALL_STAGE]=1.
- flush=1 with move=1:
  - All advance bits = 1.
  - bubble[k]=1 for 1 <= k <= FLUSH_DEPTH.
  - flush overrides load_use; no stage holds.
- load_use or flush with move=0 has no effect. The requester holds the signal until move.
- Latency:
  - A single-cycle memory (resp in the same cycle as req) gives move every cycle.
  - A response N cycles after the request gives move N cycles after issue.
- Reset: all ports IDLE, hold registers 0, error 0. Outputs during reset: advance=0, bubble=0, move=0, req_ok=all 1.
- Reset mid-transaction: pending state is discarded. A resp arriving after reset release is ignored, since the port is IDLE with no req.

Optional Feature:
HAZARD_TIMEOUT_EN
- Defined:
  - Each port has a counter, width $clog2(MAX_WAIT+1). It clears on entry to WAIT and increments each cycle in WAIT.
  - When the counter reaches MAX_WAIT with no resp, the port is forced to DONE with held_rdata=0 and error is set.
  - error is sticky until reset.
- Undefined:
  - No counters; a port waits indefinitely and error is tied to 0.

Test Plan:
1. Reset release with NUM_PORTS=2 and no req -> move=1, advance=5'b11111, bubble=0, req_ok=2'b11, error=0.
2. Port 0 req with resp 3 cycles later (rdata 32'h0000_0013); port 1 idle -> move=0 for 2 cycles, move=1 on the resp cycle, held_rdata[0]=32'h13.
3. Port 0 resp at cycle 1 and port 1 resp at cycle 4 (rdata 32'hDEAD_BEEF) -> port 0 DONE and held stable at its value cycles 1-4, req_ok[0]=0 until cycle 4, single move at cycle 4.
4. load_use=1 held until move, STALL_STAGE=2 -> at move: advance=5'b11100, bubble=5'b00100.
5. flush=1 and load_use=1 together at move -> advance=5'b11111, bubble=5'b00110.
6. HAZARD_TIMEOUT_EN defined, MAX_WAIT=8, port 1 never responds -> move=1 and error=1 eight cycles after WAIT entry, held_rdata[1]=0; error stays 1 until rst=0.
